ps2_key_tracker: RTL and testbench



---
 rtl/synth_kbd_pkg.sv | 25 ++
 rtl/ps2_frame_rx.sv | 90 +++++++++
 rtl/ps2_key_tracker.sv | 68 ++++++
 tb/tb_ps2_key_tracker.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/synth_kbd_pkg.sv
// synth_kbd_pkg: scan codes, key indices and frame FSM states for the PS/2 synth keyboard
package synth_kbd_pkg;
    localparam logic [7:0] KEY_A    = 8'h1C;
    localparam logic [7:0] KEY_S    = 8'h1B;
    localparam logic [7:0] KEY_D    = 8'h23;
    localparam logic [7:0] KEY_F    = 8'h2B;
    localparam logic [7:0] CODE_BRK = 8'hF0;
    localparam logic [7:0] CODE_EXT = 8'hE0;
    localparam logic [1:0] IDX_A = 2'd3;
    localparam logic [1:0] IDX_S = 2'd2;
    localparam logic [1:0] IDX_D = 2'd1;
    localparam logic [1:0] IDX_F = 2'd0;
    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} frame_state_t;
    // Returns {mapped, index} for a scan code.
    function automatic logic [2:0] key_lookup(input logic [7:0] code);
        return code == KEY_A ? {1'b1, IDX_A} :
               code == KEY_S ? {1'b1, IDX_S} :
               code == KEY_D ? {1'b1, IDX_D} :
               code == KEY_F ? {1'b1, IDX_F} : 3'b000;
    endfunction
    // Highest held key in fixed order A > S > D > F.
    function automatic logic [1:0] top_key(input logic [3:0] mask);
        return mask[3] ? IDX_A : mask[2] ? IDX_S : mask[1] ? IDX_D : IDX_F;
    endfunction
endpackage

// File: rtl/ps2_frame_rx.sv
// ps2_frame_rx: synchronised PS/2 frame receiver with parity, stop and timeout checks
module ps2_frame_rx
    import synth_kbd_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_error
);
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    logic [SYNC_STAGES-1:0] clk_sync, data_sync;
    logic                   clk_prev, fall, din, timeout, parity;
    logic [2:0]             count;
    logic [7:0]             shreg;
    logic [TW-1:0]          tcnt;
    frame_state_t           state, next_state;
    assign din     = data_sync[SYNC_STAGES-1];
    assign fall    = clk_prev & ~clk_sync[SYNC_STAGES-1];
    assign timeout = state != IDLE && tcnt == TW'(TIMEOUT_CYCLES - 1);
    // Bring the asynchronous pins into the clock domain and keep the last clock level for edge detect
    always_ff @(posedge clock) begin
        if (reset) begin
            clk_sync  <= '0;
            data_sync <= '0;
            clk_prev  <= 1'b0;
        end else begin
            clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
            data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
            clk_prev  <= clk_sync[SYNC_STAGES-1];
        end
    end
    // Frame state register
    always_ff @(posedge clock) begin
        state <= reset ? IDLE : next_state;
    end
    // Advance only on PS/2 falling edges; a timeout aborts unless an edge arrives the same cycle
    always_comb begin
        next_state = state;
        if (fall) begin
            case (state)
                IDLE:    next_state = din ? IDLE : DATA;
                DATA:    next_state = count == 3'd7 ? PARITY : DATA;
                PARITY:  next_state = STOP;
                default: next_state = IDLE;
            endcase
        end else if (timeout) begin
            next_state = IDLE;
        end
    end
    // Shift in data, judge the frame at the stop bit and run the inactivity counter
    always_ff @(posedge clock) begin
        byte_valid  <= 1'b0;
        frame_error <= 1'b0;
        if (reset) begin
            byte_data <= '0;
            shreg     <= '0;
            parity    <= 1'b0;
            count     <= '0;
            tcnt      <= '0;
        end else begin
            tcnt <= (fall || state == IDLE || timeout) ? '0 : tcnt + 1'b1;
            if (fall) begin
                case (state)
                    IDLE:   count <= '0;
                    DATA: begin
                        shreg[count] <= din;
                        count        <= count + 1'b1;
                    end
                    PARITY: parity <= din;
                    default: begin
                        if (din && ^{shreg, parity}) begin
                            byte_data  <= shreg;
                            byte_valid <= 1'b1;
                        end else begin
                            frame_error <= 1'b1;
                        end
                    end
                endcase
            end else if (timeout) begin
                frame_error <= 1'b1;
            end
        end
    end
endmodule

// File: rtl/ps2_key_tracker.sv
// ps2_key_tracker: decodes A/S/D/F make/break codes into a held mask and last-note priority select
module ps2_key_tracker
    import synth_kbd_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_error,
    output logic [3:0] key_held,
    output logic       note_valid,
    output logic [1:0] note_select
);
    logic       ext, brk, is_ext, is_brk;
    logic [2:0] hit;
    logic [3:0] bit_mask, held_n;
    logic [1:0] last_n;
    ps2_frame_rx #(.SYNC_STAGES(SYNC_STAGES), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_rx (
        .clock       (clock),
        .reset       (reset),
        .ps2_clk     (ps2_clk),
        .ps2_data    (ps2_data),
        .byte_valid  (byte_valid),
        .byte_data   (byte_data),
        .frame_error (frame_error)
    );
    assign is_ext   = byte_data == CODE_EXT;
    assign is_brk   = byte_data == CODE_BRK;
    assign hit      = key_lookup(byte_data);
    assign bit_mask = 4'b0001 << hit[1:0];
    // Next key mask and last-note choice; a released last note falls back to the highest held key
    always_comb begin
        held_n = key_held;
        last_n = note_select;
        if (byte_valid && !is_ext && !is_brk && !ext && hit[2]) begin
            if (!brk) begin
                held_n = key_held | bit_mask;
                last_n = (key_held & bit_mask) != 4'b0 ? note_select : hit[1:0];
            end else begin
                held_n = key_held & ~bit_mask;
                last_n = (hit[1:0] == note_select && held_n != 4'b0) ? top_key(held_n) : note_select;
            end
        end
    end
    // Register key state and prefix flags; prefixes persist across frame errors
    always_ff @(posedge clock) begin
        if (reset) begin
            key_held    <= '0;
            note_valid  <= 1'b0;
            note_select <= '0;
            ext         <= 1'b0;
            brk         <= 1'b0;
        end else begin
            key_held    <= held_n;
            note_valid  <= |held_n;
            note_select <= last_n;
            if (byte_valid) begin
                ext <= is_ext ? 1'b1 : is_brk ? ext : 1'b0;
                brk <= is_brk ? 1'b1 : is_ext ? brk : 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_ps2_key_tracker.sv
// tb_ps2_key_tracker: scoreboard bench for PS/2 framing and A/S/D/F key tracking
module tb_ps2_key_tracker;
    localparam int T = 200;
    localparam int H = 6;
    typedef struct packed {
        logic       err;
        logic [7:0] data;
    } ev_t;
    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       byte_valid, frame_error, note_valid;
    logic [7:0] byte_data;
    logic [3:0] key_held;
    logic [1:0] note_select;
    ev_t        sb[$];
    int         tests = 0;
    int         fails = 0;

    ps2_key_tracker #(.SYNC_STAGES(2), .TIMEOUT_CYCLES(T)) dut (
        .clock       (clock),
        .reset       (reset),
        .ps2_clk     (ps2_clk),
        .ps2_data    (ps2_data),
        .byte_valid  (byte_valid),
        .byte_data   (byte_data),
        .frame_error (frame_error),
        .key_held    (key_held),
        .note_valid  (note_valid),
        .note_select (note_select)
    );

    always #5 clock = ~clock;

    // Advance one cycle and pop/compare the scoreboard whenever the receiver reports a frame
    task automatic tick();
        ev_t e;
        @(negedge clock);
        if (byte_valid || frame_error) begin
            tests++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL sb_unexpected got valid=%b err=%b data=%h expected no event", byte_valid, frame_error, byte_data);
            end else begin
                e = sb.pop_front();
                if (frame_error !== e.err || byte_valid !== !e.err || (!e.err && byte_data !== e.data)) begin
                    fails++;
                    $display("FAIL sb_event got valid=%b err=%b data=%h expected err=%b data=%h", byte_valid, frame_error, byte_data, e.err, e.data);
                end
            end
        end
    endtask

    task automatic send_bits(input logic [10:0] f, input int n);
        for (int i = 0; i < n; i++) begin
            ps2_data = f[i];
            ps2_clk  = 1'b1;
            repeat (H) tick();
            ps2_clk = 1'b0;
            repeat (H) tick();
        end
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        repeat (H) tick();
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par_ok, input logic stop);
        logic par;
        par = par_ok ? ~^d : ^d;
        sb.push_back((stop && par_ok) ? {1'b0, d} : {1'b1, 8'h00});
        send_bits({stop, par, d, 1'b0}, 11);
        repeat (2 * H) tick();
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        repeat (2) tick();
    endtask

    task automatic test_reset();
        do_reset();
        tests++;
        if ({byte_valid, byte_data, frame_error, key_held, note_valid, note_select} !== 17'b0) begin
            fails++;
            $display("FAIL reset_state got bv=%b bd=%h fe=%b held=%b nv=%b sel=%0d expected all 0", byte_valid, byte_data, frame_error, key_held, note_valid, note_select);
        end
    endtask

    task automatic test_single_make();
        do_reset();
        send_frame(8'h1C, 1'b1, 1'b1);
        tests++;
        if (byte_data !== 8'h1C) begin
            fails++;
            $display("FAIL make_a_byte got %h expected 1c", byte_data);
        end
        tests++;
        if ({key_held, note_valid, note_select} !== 7'b1000_1_11) begin
            fails++;
            $display("FAIL make_a_keys got held=%b nv=%b sel=%0d expected 1000 1 3", key_held, note_valid, note_select);
        end
    endtask

    task automatic test_make_break();
        do_reset();
        send_frame(8'h1C, 1'b1, 1'b1);
        send_frame(8'h23, 1'b1, 1'b1);
        tests++;
        if ({key_held, note_valid, note_select} !== 7'b1010_1_01) begin
            fail_line("ad_make", 7'b1010_1_01);
        end
        send_frame(8'hF0, 1'b1, 1'b1);
        send_frame(8'h23, 1'b1, 1'b1);
        tests++;
        if ({key_held, note_valid, note_select} !== 7'b1000_1_11) begin
            fail_line("d_break_fallback", 7'b1000_1_11);
        end
        send_frame(8'hF0, 1'b1, 1'b1);
        send_frame(8'h1C, 1'b1, 1'b1);
        tests++;
        if ({key_held, note_valid, note_select} !== 7'b0000_0_11) begin
            fail_line("all_released_hold_sel", 7'b0000_0_11);
        end
    endtask

    task automatic test_typematic();
        do_reset();
        send_frame(8'h1B, 1'b1, 1'b1);
        send_frame(8'h1B, 1'b1, 1'b1);
        tests++;
        if ({key_held, note_valid, note_select} !== 7'b0100_1_10) begin
            fail_line("s_repeat", 7'b0100_1_10);
        end
        send_frame(8'h2B, 1'b1, 1'b1);
        tests++;
        if ({key_held, note_valid, note_select} !== 7'b0101_1_00) begin
            fail_line("f_make", 7'b0101_1_00);
        end
        send_frame(8'hF0, 1'b1, 1'b1);
        send_frame(8'h1B, 1'b1, 1'b1);
        tests++;
        if ({key_held, note_valid, note_select} !== 7'b0001_1_00) begin
            fail_line("s_break_not_last", 7'b0001_1_00);
        end
    endtask

    task automatic test_bad_frames();
        do_reset();
        send_frame(8'h1C, 1'b1, 1'b1);
        send_frame(8'h2B, 1'b0, 1'b1);
        tests++;
        if ({key_held, note_valid, note_select} !== 7'b1000_1_11) begin
            fail_line("parity_err_keys", 7'b1000_1_11);
        end
        send_frame(8'h2B, 1'b1, 1'b0);
        tests++;
        if ({key_held, note_valid, note_select, byte_data} !== {7'b1000_1_11, 8'h1C}) begin
            fail_line("stop_err_keys", 7'b1000_1_11);
        end
    endtask

    task automatic test_extended();
        do_reset();
        send_frame(8'hE0, 1'b1, 1'b1);
        send_frame(8'h1C, 1'b1, 1'b1);
        tests++;
        if ({key_held, note_valid} !== 5'b0000_0) begin
            fail_line("ext_make_ignored", 7'b0000_0_00);
        end
        send_frame(8'hE0, 1'b1, 1'b1);
        send_frame(8'hF0, 1'b1, 1'b1);
        send_frame(8'h1C, 1'b1, 1'b1);
        tests++;
        if ({key_held, note_valid} !== 5'b0000_0) begin
            fail_line("ext_break_ignored", 7'b0000_0_00);
        end
        send_frame(8'h1C, 1'b1, 1'b1);
        tests++;
        if ({key_held, note_valid, note_select} !== 7'b1000_1_11) begin
            fail_line("plain_after_ext", 7'b1000_1_11);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        sb.push_back({1'b1, 8'h00});
        send_bits({1'b1, 1'b0, 8'h2B, 1'b0}, 4);
        repeat (T + 20) tick();
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL timeout_error got %0d pending events expected 0", sb.size());
            sb.delete();
        end
        send_frame(8'h1B, 1'b1, 1'b1);
        tests++;
        if ({key_held, note_valid, note_select} !== 7'b0100_1_10) begin
            fail_line("frame_after_timeout", 7'b0100_1_10);
        end
    endtask

    task automatic test_reset_midframe();
        do_reset();
        send_frame(8'h1C, 1'b1, 1'b1);
        send_bits({1'b1, 1'b1, 8'h23, 1'b0}, 5);
        reset = 1'b1;
        repeat (3) tick();
        tests++;
        if ({byte_valid, byte_data, frame_error, key_held, note_valid, note_select} !== 17'b0) begin
            fails++;
            $display("FAIL midframe_reset got bv=%b bd=%h fe=%b held=%b nv=%b sel=%0d expected all 0", byte_valid, byte_data, frame_error, key_held, note_valid, note_select);
        end
        reset = 1'b0;
        repeat (T + 20) tick();
        tests++;
        if ({key_held, note_valid, byte_data} !== 13'b0) begin
            fails++;
            $display("FAIL midframe_quiet got held=%b nv=%b bd=%h expected 0 0 00", key_held, note_valid, byte_data);
        end
    endtask

    task automatic fail_line(input string name, input logic [6:0] exp);
        fails++;
        $display("FAIL %s got held=%b nv=%b sel=%0d expected held=%b nv=%b sel=%0d", name, key_held, note_valid, note_select, exp[6:3], exp[2], exp[1:0]);
    endtask

    initial begin
        test_reset();
        test_single_make();
        test_make_break();
        test_typematic();
        test_bad_frames();
        test_extended();
        test_timeout();
        test_reset_midframe();
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL sb_drain got %0d pending events expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
